// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_issue_ctrl
// Description : EX-stage sequencer around the iterative divider. Holds the
//               operands for the whole divide, then hands the selected
//               quotient/remainder to MEM.
// Revision    : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_x,
   input  logic [31:0]      in_y,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy,
   output logic             div_en,
   output logic             div_signed,
   output logic [31:0]      div_x,
   output logic [31:0]      div_y,
   input  logic [31:0]      div_s,
   input  logic [31:0]      div_r,
   input  logic             div_complete
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_op;
   logic [TAG_W-1:0]   r_tag;
   logic [31:0]        r_div_x;
   logic [31:0]        r_div_y;
   logic               r_out_valid;
   logic [31:0]        r_out_result;
   logic [TAG_W-1:0]   r_out_tag;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_capture;
   logic               w_out_clear;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_capture   = 1'b0;
      w_out_clear = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
         end
         ST_BUSY: begin
            if (div_complete) begin
               // A flush landing on the completion cycle simply drops the result.
               w_state_nxt = flush ? ST_IDLE : ST_DONE;
               w_capture   = ~flush;
            end else if (flush) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The divider counter must run to completion before it is reusable.
            if (div_complete) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (flush) begin
               w_out_clear = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (out_ready) begin
               w_out_clear = 1'b1;
               w_in_ready  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_in_ready = w_in_ready & ~flush;
      w_accept   = in_valid & w_in_ready;
      if (w_accept) begin
         w_state_nxt = ST_BUSY;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_op         <= 2'b00;
         r_tag        <= '0;
         r_div_x      <= 32'd0;
         r_div_y      <= 32'd0;
         r_out_valid  <= 1'b0;
         r_out_result <= 32'd0;
         r_out_tag    <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= in_op;
            r_tag   <= in_tag;
            r_div_x <= in_x;
            r_div_y <= in_y;
         end
         if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_result <= r_op[0] ? div_r : div_s;
            r_out_tag    <= r_tag;
         end else if (w_out_clear) begin
            r_out_valid  <= 1'b0;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_tag    = r_out_tag;
   assign busy       = (r_state != ST_IDLE);
   assign div_en     = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
   assign div_signed = ~r_op[1];
   assign div_x      = r_div_x;
   assign div_y      = r_div_y;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_issue_ctrl
// Description : Directed self-checking bench for div_issue_ctrl with a
//               34-cycle behavioural divider model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             resetn;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_x;
   logic [31:0]      in_y;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic             busy;
   logic             div_en;
   logic             div_signed;
   logic [31:0]      div_x;
   logic [31:0]      div_y;
   logic [31:0]      div_s;
   logic [31:0]      div_r;
   logic             div_complete;

   int errors = 0;
   int checks = 0;
   int n;
   logic [31:0] hold_res;
   logic [31:0] hold_tag;

   always #5 clk = ~clk;

   div_issue_ctrl #(.TAG_W(TAG_W)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy),
      .div_en(div_en), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
      .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
   );

   // Divider model: counter advances only while div is high, done on 34th cycle.
   logic [5:0] mcnt;
   always_ff @(posedge clk) begin
      if (!resetn) mcnt <= 6'd0;
      else if (div_en) mcnt <= (mcnt == 6'd33) ? 6'd0 : mcnt + 6'd1;
   end
   assign div_complete = div_en && (mcnt == 6'd33);

   always_comb begin
      int sx, sy;
      div_s = 32'd0;
      div_r = 32'd0;
      sx = $signed(div_x);
      sy = $signed(div_y);
      if (div_y != 32'd0) begin
         if (div_signed) begin
            div_s = sx / sy;
            div_r = sx % sy;
         end else begin
            div_s = div_x / div_y;
            div_r = div_x % div_y;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Call at a negedge; returns at the negedge of cycle 1 after the accept.
   task automatic start_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic [TAG_W-1:0] tag);
      in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
      #1 check("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      n = 1;
      check("div_en_first_cycle", {31'd0, div_en}, 32'd1);
      check("div_x_latched", div_x, x);
      check("div_y_latched", div_y, y);
      check("div_signed", {31'd0, div_signed}, {31'd0, ~op[1]});
   endtask

   task automatic wait_result(input string name, input logic [31:0] exp_res,
                              input logic [TAG_W-1:0] exp_tag);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_latency"}, n, 32'd35);
      check({name, "_result"}, out_result, exp_res);
      check({name, "_tag"}, {27'd0, out_tag}, {27'd0, exp_tag});
      check({name, "_div_en_done"}, {31'd0, div_en}, 32'd0);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("released_out_valid", {31'd0, out_valid}, 32'd0);
      check("released_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      resetn = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_x = 32'd0; in_y = 32'd0;
      in_tag = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_tag", {27'd0, out_tag}, 32'd0);
      check("rst_div_en", {31'd0, div_en}, 32'd0);
      check("rst_div_x", div_x, 32'd0);
      check("rst_div_y", div_y, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Signed DIV -7/2
      start_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
      wait_result("div_w", 32'hFFFF_FFFD, 5'd3);
      release_result();

      // Unsigned remainder 0xFFFFFFFF % 10
      start_op(2'b11, 32'hFFFF_FFFF, 32'd10, 5'd7);
      wait_result("mod_wu", 32'd5, 5'd7);
      release_result();

      // Signed MOD -7 % 2, then backpressure
      start_op(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd9);
      wait_result("mod_w", 32'hFFFF_FFFF, 5'd9);
      hold_res = out_result;
      hold_tag = {27'd0, out_tag};
      in_valid = 1'b1; in_op = 2'b10; in_x = 32'd1; in_y = 32'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_result", out_result, hold_res);
         check("bp_tag", {27'd0, out_tag}, hold_tag);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_busy", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      start_op(2'b10, 32'd100, 32'd7, 5'd4);
      check("b2b_out_valid_dropped", {31'd0, out_valid}, 32'd0);
      wait_result("b2b_divu", 32'd14, 5'd4);
      release_result();

      // Flush at cycle 10 of BUSY: divider must be drained
      start_op(2'b00, 32'd55, 32'd5, 5'd2);
      repeat (9) begin @(negedge clk); n++; end
      flush = 1'b1;
      #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      n++;
      while (busy && n < 100) begin
         if (!div_en || out_valid) begin
            check("drain_div_en", {31'd0, div_en}, 32'd1);
            check("drain_out_valid", {31'd0, out_valid}, 32'd0);
         end
         @(negedge clk);
         n++;
      end
      check("drain_idle_cycle", n, 32'd35);
      check("drain_no_out_valid", {31'd0, out_valid}, 32'd0);
      start_op(2'b00, 32'd100, 32'd7, 5'd11);
      wait_result("after_drain", 32'd14, 5'd11);
      release_result();

      // Flush coincident with div_complete
      start_op(2'b00, 32'd9, 32'd3, 5'd5);
      repeat (33) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("coinc_out_valid", {31'd0, out_valid}, 32'd0);
      check("coinc_busy", {31'd0, busy}, 32'd0);

      // Flush in DONE
      start_op(2'b00, 32'd20, 32'd3, 5'd6);
      wait_result("pre_flush_done", 32'd6, 5'd6);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("done_flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("done_flush_busy", {31'd0, busy}, 32'd0);

      // Reset mid-BUSY
      start_op(2'b00, 32'd77, 32'd3, 5'd8);
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_result", out_result, 32'd0);
      check("midrst_out_tag", {27'd0, out_tag}, 32'd0);
      check("midrst_div_en", {31'd0, div_en}, 32'd0);
      check("midrst_div_x", div_x, 32'd0);
      check("midrst_div_y", div_y, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      start_op(2'b00, 32'h8000_0000, 32'd2, 5'd1);
      wait_result("after_rst", 32'hC000_0000, 5'd1);
      release_result();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage sequencer that sits directly upstream and downstream of the iterative divider.
- Accepts one DIV.W/MOD.W/DIV.WU/MOD.WU op from EX over valid/ready.
- Registers and holds the operands, drives the divider's `div`/`div_signed`/`x`/`y` until `complete`, then returns quotient or remainder to MEM over valid/ready.
- Handles pipeline flush without corrupting the divider's internal counter.

Parameters:
- TAG_W, 5, width of destination-register tag carried alongside the op.

Ports:
- clk  input  1  single clock
- resetn  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- in_valid  input  1  EX presents a divide op
- in_ready  output  1  controller can accept an op this cycle
- in_op  input  2  bit0: 1 = remainder (MOD), 0 = quotient (DIV); bit1: 1 = unsigned
- in_x  input  32  dividend
- in_y  input  32  divisor
- in_tag  input  TAG_W  destination register
- flush  input  1  cancel any in-flight or pending op (exception/ertn)
- out_valid  output  1  result available
- out_ready  input  1  MEM accepts result
- out_result  output  32  selected quotient or remainder
- out_tag  output  TAG_W  tag of result
- busy  output  1  state != IDLE; used by EX for stall/hazard
- div_en  output  1  to divider `div`
- div_signed  output  1  to divider `div_signed` (= ~op[1])
- div_x  output  32  to divider `x`, registered
- div_y  output  32  to divider `y`, registered
- div_s  input  32  divider quotient
- div_r  input  32  divider remainder
- div_complete  input  1  divider done pulse

Behaviour:
- Reset (resetn=0 at clk edge):
  - state=IDLE; out_valid=0, out_result=0, out_tag=0, div_en=0, div_x=0, div_y=0, op reg=0.
  - in_ready=1 once reset is released.
  - The divider shares resetn, so reset mid-op needs no drain.
- States: IDLE, BUSY, DRAIN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready); forced 0 when flush=1.
- Accept = in_valid & in_ready & ~flush.
  - On accept, latch in_x→div_x, in_y→div_y, in_op, in_tag; go to BUSY.
- div_en = 1 exactly in BUSY and DRAIN; 0 otherwise.
- div_x, div_y and div_signed are held constant for the whole BUSY/DRAIN period, because the divider samples them every iteration.
- BUSY:
  - On div_complete with no flush: out_result ← op[0] ? div_r : div_s; out_tag ← tag; out_valid ← 1; go to DONE.
  - On flush without div_complete: go to DRAIN.
  - On flush with div_complete in the same cycle: discard the result, go to IDLE.
- DRAIN:
  - Keep div_en=1 until div_complete, then go to IDLE with no output.
  - div_en must never drop mid-operation: the divider counter only advances/clears while `div` is high, and an early drop leaves it stale.
  - flush in DRAIN is ignored.
- DONE:
  - out_valid held with stable out_result/out_tag until out_ready.
  - On out_ready: out_valid ← 0. If a new accept happens the same cycle, go to BUSY with new operands; otherwise go to IDLE.
  - On flush: out_valid ← 0, go to IDLE. flush overrides out_ready.
- Latency: accept at edge E → div_en high from the cycle after E → div_complete in the 34th div_en cycle → out_valid visible 35 cycles after the accept cycle.
- Back-to-back ops: at most one idle cycle of div_en between ops (the DONE→BUSY transition deasserts nothing; div_en goes low in DONE).
- No special-casing of y=0 or 0x80000000/−1; the result is whatever the divider returns, passed unmodified.
- in_valid while busy is simply not accepted; EX must hold its op.

Test Plan:
- Signed DIV: in_op=00, x=−7 (0xFFFFFFF9), y=2 → out_result=0xFFFFFFFD (−3), out_valid exactly 35 cycles after accept, tag echoed.
- MOD.WU: in_op=11, x=0xFFFFFFFF, y=10 → out_result=5. Signed MOD in_op=01, x=−7, y=2 → 0xFFFFFFFF.
- Backpressure: out_ready=0 for 10 cycles after out_valid → result and tag stable, in_ready=0, busy=1. Then out_ready=1 with in_valid=1 → new op accepted the same cycle.
- Flush at cycle 10 of BUSY → div_en stays 1 until div_complete, no out_valid, then IDLE. A following op 100/7 returns 14 with correct latency (counter not stale).
- Flush coincident with div_complete → no out_valid, IDLE next cycle. Flush in DONE → out_valid drops next cycle.
- resetn=0 mid-BUSY for 1 cycle → all outputs 0, IDLE. Next op 0x80000000/2 signed → 0xC0000000.
